// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared pixel, FIFO entry and crop FSM types
package isp_pkg;

    typedef logic [23:0] rgb888_t;

    typedef struct packed {
        logic    sof;
        logic    eol;
        rgb888_t rgb;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } crop_state_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock show-ahead FIFO, full checked before same-cycle pop
module sync_fifo_fwft #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // full/empty come from the registered count, so a write is refused when
    // full even if the head pops in the same cycle
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // storage array is not reset; the head is only observed while count != 0
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rgb_win_crop.sv
// rtl/rgb_win_crop.sv - RGB888 window crop into show-ahead FIFO; optional WIN_CROP_FRAME_CNT_EN adds frame_cnt
module rgb_win_crop
    import isp_pkg::*;
#(
    parameter logic [10:0] RAW_HPIXEL = 11'd1936,
    parameter logic [10:0] RAW_VPIXEL = 11'd1088,
    parameter logic [10:0] WIN_X      = 11'd500,
    parameter logic [10:0] WIN_Y      = 11'd500,
    parameter logic [10:0] WIN_W      = 11'd640,
    parameter logic [10:0] WIN_H      = 11'd480,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_href,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic        out_sof,
    output logic        out_eol,
    output logic        ovf
`ifdef WIN_CROP_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;
    // window bounds widened to 12 bits so WIN_X+WIN_W cannot wrap
    localparam logic [11:0] X_LO  = {1'b0, WIN_X};
    localparam logic [11:0] X_HI  = {1'b0, WIN_X} + {1'b0, WIN_W} - 12'd1;
    localparam logic [11:0] Y_LO  = {1'b0, WIN_Y};
    localparam logic [11:0] Y_HI  = {1'b0, WIN_Y} + {1'b0, WIN_H} - 12'd1;

    logic [10:0]       h_cnt;
    logic [10:0]       v_cnt;
    logic [11:0]       h_ext;
    logic [11:0]       v_ext;
    logic              in_win;
    logic              at_origin;
    logic              pass_now;
    logic              fifo_wr;
    logic              overflow_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count_unused;
    crop_state_t       state;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;

    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign in_win    = (h_ext >= X_LO) && (h_ext <= X_HI) &&
                       (v_ext >= Y_LO) && (v_ext <= Y_HI);
    assign at_origin = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    // the (0,0) pixel that ends DROP is already judged under PASS rules
    assign pass_now  = (state == ST_PASS) || at_origin;

    assign fifo_wr      = in_href && pass_now && in_win && !fifo_full;
    assign overflow_hit = in_href && pass_now && in_win && fifo_full;

    assign wr_entry = '{sof: (h_cnt == WIN_X) && (v_cnt == WIN_Y),
                        eol: (h_ext == X_HI),
                        rgb: in_rgb};

    // raster position of the pixel currently on in_rgb
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (in_href) begin
            if (h_cnt == RAW_HPIXEL - 11'd1) begin
                h_cnt <= 11'd0;
                v_cnt <= (v_cnt == RAW_VPIXEL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // PASS/DROP: an overflow drops the rest of the frame to keep output frames whole
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_PASS;
            ovf   <= 1'b0;
        end else if (in_href) begin
            if (overflow_hit) begin
                state <= ST_DROP;
                ovf   <= 1'b1;
            end else if (pass_now) begin
                state <= ST_PASS;
            end
        end
    end

`ifdef WIN_CROP_FRAME_CNT_EN
    // counts every raw frame start, independent of drop state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 16'd0;
        end else if (in_href && at_origin) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    sync_fifo_fwft #(
        .WIDTH (FIFO_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_unused)
    );

    // head fields are forced low while empty so stale storage never leaks out
    assign out_valid = !fifo_empty;
    assign out_rgb   = out_valid ? head.rgb : 24'd0;
    assign out_sof   = out_valid & head.sof;
    assign out_eol   = out_valid & head.eol;

endmodule
